// File: rtl/display_pkg.sv
// Shared screen geometry, colours and FSM states for the falling-tile display.
// Also holds the small helpers used for tile start positions and hit-zone tests.
package display_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int LANE_W    = 40;
   localparam int TILE_H    = 30;
   localparam int HIT_TOP   = 90;
   localparam int HIT_ROW   = HIT_TOP - 1;
   localparam int NUM_LANES = 4;

   localparam logic [2:0] COLOR_OVER = 3'b100;
   localparam logic [2:0] COLOR_TILE = 3'b000;
   localparam logic [2:0] COLOR_HIT  = 3'b001;
   localparam logic [2:0] COLOR_BG   = 3'b111;
   localparam logic [2:0] COLOR_GRID = 3'b010;

   typedef enum logic [1:0] {
      DRAW,
      UPDATE,
      WAIT
   } state_t;

   // Lanes start staggered one tile height apart: 90, 60, 30, 0.
   function automatic logic [6:0] tile_start(input int lane);
      return 7'(HIT_TOP - TILE_H * lane);
   endfunction

   function automatic logic in_hit_zone(input logic [6:0] top);
      logic [7:0] bottom;
      bottom = {1'b0, top} + 8'(TILE_H - 1);
      return (bottom >= 8'(HIT_TOP)) && (bottom <= 8'(SCREEN_H - 1));
   endfunction

endpackage

// File: rtl/display_key_edge.sv
// key_edge: two-flop synchroniser for one active-low button plus a 1->0 edge detector.
// Reset parks all flops at 1 so a held-released button never looks like a press.
module key_edge (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic fall
);

   logic sync_a;
   logic sync_b;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
         prev   <= 1'b1;
      end else begin
         sync_a <= key;
         sync_b <= sync_a;
         prev   <= sync_b;
      end
   end

   assign fall = prev & ~sync_b;

endmodule

// File: rtl/display.sv
// Four-lane falling-tile game rendered to a 160x120 pixel-plot VGA adapter.
// Optional lane dividers are enabled with the DISPLAY_LANE_GRID_EN macro.
module display
   import display_pkg::*;
#(
   parameter int FRAME_CYCLES = 833333,
   parameter int STEP         = 1
) (
   input  logic       CLOCK_50,
   input  logic [7:0] SW,
   input  logic [3:0] KEY,
   output logic [7:0] VGA_X,
   output logic [6:0] VGA_Y,
   output logic [2:0] VGA_COLOR,
   output logic       plot,
   output logic [9:0] LEDR
);

   localparam int CNT_W = $clog2(FRAME_CYCLES);

   logic reset;
   logic paused;
   logic unused_sw;

   assign reset     = SW[0];
   assign paused    = SW[1];
   assign unused_sw = ^SW[7:2];

   state_t state;
   state_t next_state;

   logic [7:0]       scan_x;
   logic [6:0]       scan_y;
   logic             scan_last;
   logic [CNT_W-1:0] frame_cnt;

   logic [6:0] tile_y    [NUM_LANES];
   logic [6:0] tile_next [NUM_LANES];

   logic [7:0]           score;
   logic [7:0]           score_next;
   logic [8:0]           score_sum;
   logic [1:0]           misses;
   logic [1:0]           misses_next;
   logic [4:0]           miss_sum;
   logic                 game_over;
   logic [NUM_LANES-1:0] pending;
   logic [NUM_LANES-1:0] key_fall;
   logic [2:0]           hit_count;
   logic [3:0]           miss_count;

   logic [1:0] lane;
   logic [6:0] tile_top;
   logic       in_tile;
   logic       on_grid;
   logic [2:0] pix_color;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_key
      key_edge u_key (
         .clk  (CLOCK_50),
         .reset(reset),
         .key  (KEY[g]),
         .fall (key_fall[g])
      );
   end

   assign scan_last = (scan_x == 8'(SCREEN_W - 1)) && (scan_y == 7'(SCREEN_H - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state <= DRAW;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         DRAW:    if (scan_last) next_state = UPDATE;
         UPDATE:  next_state = WAIT;
         WAIT:    if (frame_cnt == CNT_W'(FRAME_CYCLES - 1)) next_state = DRAW;
         default: next_state = DRAW;
      endcase
   end

   // The frame counter restarts with every DRAW so one frame spans exactly FRAME_CYCLES.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (state == WAIT && next_state == DRAW) begin
         frame_cnt <= '0;
      end else begin
         frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         scan_x <= '0;
         scan_y <= '0;
      end else if (state == DRAW) begin
         if (scan_x == 8'(SCREEN_W - 1)) begin
            scan_x <= '0;
            scan_y <= scan_last ? 7'd0 : scan_y + 7'd1;
         end else begin
            scan_x <= scan_x + 8'd1;
         end
      end
   end

   always_comb begin
      lane = 2'd3;
      if (scan_x < 8'(LANE_W)) begin
         lane = 2'd0;
      end else if (scan_x < 8'(2 * LANE_W)) begin
         lane = 2'd1;
      end else if (scan_x < 8'(3 * LANE_W)) begin
         lane = 2'd2;
      end
      tile_top = tile_y[lane];
      in_tile  = ({1'b0, scan_y} >= {1'b0, tile_top}) &&
                 ({1'b0, scan_y} <= {1'b0, tile_top} + 8'(TILE_H - 1));
`ifdef DISPLAY_LANE_GRID_EN
      on_grid = (scan_x == 8'(LANE_W - 1)) || (scan_x == 8'(2 * LANE_W - 1)) ||
                (scan_x == 8'(3 * LANE_W - 1));
`else
      on_grid = 1'b0;
`endif
      if (game_over) begin
         pix_color = COLOR_OVER;
      end else if (in_tile) begin
         pix_color = COLOR_TILE;
      end else if (on_grid) begin
         pix_color = COLOR_GRID;
      end else if (scan_y == 7'(HIT_ROW)) begin
         pix_color = COLOR_HIT;
      end else begin
         pix_color = COLOR_BG;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         VGA_X     <= '0;
         VGA_Y     <= '0;
         VGA_COLOR <= '0;
         plot      <= 1'b0;
      end else if (state == DRAW) begin
         VGA_X     <= scan_x;
         VGA_Y     <= scan_y;
         VGA_COLOR <= pix_color;
         plot      <= 1'b1;
      end else begin
         plot      <= 1'b0;
      end
   end

   // A scored lane restarts at the top and skips this frame's fall; a missed press still falls.
   always_comb begin : update_calc
      logic       lane_scored;
      logic [7:0] advanced;
      lane_scored = 1'b0;
      advanced    = '0;
      hit_count   = '0;
      miss_count  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         tile_next[i] = tile_y[i];
         lane_scored  = 1'b0;
         advanced     = {1'b0, tile_y[i]} + 8'(STEP);
         if (pending[i]) begin
            if (in_hit_zone(tile_y[i])) begin
               hit_count    = hit_count + 3'd1;
               tile_next[i] = '0;
               lane_scored  = 1'b1;
            end else begin
               miss_count = miss_count + 4'd1;
            end
         end
         if (!paused && !lane_scored) begin
            if (advanced > 8'(SCREEN_H - 1)) begin
               tile_next[i] = '0;
               miss_count   = miss_count + 4'd1;
            end else begin
               tile_next[i] = advanced[6:0];
            end
         end
      end
      score_sum   = {1'b0, score} + 9'(hit_count);
      score_next  = score_sum[8] ? 8'hFF : score_sum[7:0];
      miss_sum    = 5'(misses) + 5'(miss_count);
      misses_next = (miss_sum >= 5'd3) ? 2'd3 : miss_sum[1:0];
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            tile_y[i] <= tile_start(i);
         end
         score     <= '0;
         misses    <= '0;
         game_over <= 1'b0;
         pending   <= '0;
      end else if (state == UPDATE) begin
         pending <= '0;
         if (!game_over) begin
            for (int i = 0; i < NUM_LANES; i++) begin
               tile_y[i] <= tile_next[i];
            end
            score     <= score_next;
            misses    <= misses_next;
            game_over <= (misses_next == 2'd3);
         end
      end else if (!game_over) begin
         pending <= pending | key_fall;
      end
   end

   assign LEDR = {misses, score};

endmodule

// File: tb/tb_display.sv
// Self-checking bench for display: a behavioural game model predicts each frame,
// the predicted frames queue up as keys are driven and are popped as the DUT draws them.
module tb_display;

   localparam int FRAME_CYCLES_TB = 20000;
   localparam int STEP_TB         = 29;
   localparam int PIXELS          = 19200;

   typedef struct packed {
      logic [3:0][6:0] ty;
      logic            go;
      logic [7:0]      score;
      logic [1:0]      misses;
   } frame_rec_t;

   logic       clk = 1'b0;
   logic [7:0] sw;
   logic [3:0] key;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_color;
   logic       plot;
   logic [9:0] ledr;

   int checks;
   int failures;

   int  mt [4];
   int  mscore;
   int  mmiss;
   bit  mgo;

   frame_rec_t sb[$];
   logic [2:0] frame_buf [PIXELS];

   always #5 clk = ~clk;

   display #(
      .FRAME_CYCLES(FRAME_CYCLES_TB),
      .STEP        (STEP_TB)
   ) dut (
      .CLOCK_50 (clk),
      .SW       (sw),
      .KEY      (key),
      .VGA_X    (vga_x),
      .VGA_Y    (vga_y),
      .VGA_COLOR(vga_color),
      .plot     (plot),
      .LEDR     (ledr)
   );

   task automatic model_reset();
      mt[0] = 90; mt[1] = 60; mt[2] = 30; mt[3] = 0;
      mscore = 0;
      mmiss  = 0;
      mgo    = 1'b0;
   endtask

   task automatic model_update(input logic [3:0] presses, input logic paused);
      int sc;
      int mi;
      int ny;
      bit scored;
      sc = 0;
      mi = 0;
      if (mgo) return;
      for (int i = 0; i < 4; i++) begin
         scored = 1'b0;
         if (presses[i]) begin
            if (mt[i] + 29 >= 90 && mt[i] + 29 <= 119) begin
               sc++;
               mt[i]  = 0;
               scored = 1'b1;
            end else begin
               mi++;
            end
         end
         if (!paused && !scored) begin
            ny = mt[i] + STEP_TB;
            if (ny > 119) begin
               mt[i] = 0;
               mi++;
            end else begin
               mt[i] = ny;
            end
         end
      end
      mscore = (mscore + sc > 255) ? 255 : mscore + sc;
      mmiss  = (mmiss + mi >= 3) ? 3 : mmiss + mi;
      if (mmiss == 3) mgo = 1'b1;
   endtask

   function automatic frame_rec_t model_rec();
      frame_rec_t r;
      for (int i = 0; i < 4; i++) r.ty[i] = 7'(mt[i]);
      r.go     = mgo;
      r.score  = 8'(mscore);
      r.misses = 2'(mmiss);
      return r;
   endfunction

   function automatic logic [2:0] exp_color(input frame_rec_t r, input int x, input int y);
      int ty;
      if (r.go) return 3'b100;
      ty = int'(r.ty[x / 40]);
      if (y >= ty && y <= ty + 29) return 3'b000;
`ifdef DISPLAY_LANE_GRID_EN
      if (x % 40 == 39) return 3'b010;
`endif
      if (y == 89) return 3'b001;
      return 3'b111;
   endfunction

   // Draws one frame against the head of the scoreboard; presses keys early in the frame.
   task automatic run_frame(input logic [3:0] press_mask, input int abort_at, output bit aborted);
      frame_rec_t rec;
      int waited;
      int bad;
      int first_bad;
      int x;
      int y;
      logic [2:0] exp_c;
      logic [7:0] got_x;
      logic [6:0] got_y;
      logic [2:0] got_c;
      logic       got_p;
      aborted   = 1'b0;
      bad       = 0;
      first_bad = -1;
      got_x = '0; got_y = '0; got_c = '0; got_p = 1'b0;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries, required at least 1");
         return;
      end
      rec = sb.pop_front();
      waited = 0;
      while (plot !== 1'b1 && waited < FRAME_CYCLES_TB + 10) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (plot !== 1'b1) begin
         failures++;
         $display("[TB] FAIL frame_start: got plot=%b after %0d cycles, required 1", plot, waited);
         return;
      end
      checks++;
      if (ledr !== {rec.misses, rec.score}) begin
         failures++;
         $display("[TB] FAIL frame_ledr: got %h, required %h", ledr, {rec.misses, rec.score});
      end
      for (int idx = 0; idx < PIXELS; idx++) begin
         x = idx % 160;
         y = idx / 160;
         exp_c = exp_color(rec, x, y);
         if (plot !== 1'b1 || vga_x !== 8'(x) || vga_y !== 7'(y) || vga_color !== exp_c) begin
            if (bad == 0) begin
               first_bad = idx;
               got_x = vga_x; got_y = vga_y; got_c = vga_color; got_p = plot;
            end
            bad++;
         end
         frame_buf[idx] = vga_color;
         if (idx == 100) begin
            key = ~press_mask;
            model_update(press_mask, sw[1]);
            sb.push_back(model_rec());
         end
         if (idx == 103) key = 4'hF;
         if (idx == abort_at) begin
            aborted = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("[TB] FAIL frame_pixels: got %0d bad pixels (first idx %0d: plot=%b x=%0d y=%0d c=%b, required c=%b), required 0",
                  bad, first_bad, got_p, got_x, got_y, got_c,
                  exp_color(rec, first_bad % 160, first_bad / 160));
      end
      if (!aborted) begin
         checks++;
         if (plot !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame_end_plot: got %b, required 0", plot);
         end
      end
   endtask

   task automatic check_ledr_after_update(input string name, input logic [9:0] required);
      repeat (2) @(negedge clk);
      checks++;
      if (ledr !== required) begin
         failures++;
         $display("[TB] FAIL %s: got LEDR=%h, required %h", name, ledr, required);
      end
   endtask

   task automatic test_reset();
      sw  = 8'h01;
      key = 4'hF;
      repeat (3) @(negedge clk);
      checks++;
      if (vga_x !== 8'd0) begin failures++; $display("[TB] FAIL reset_x: got %0d, required 0", vga_x); end
      checks++;
      if (vga_y !== 7'd0) begin failures++; $display("[TB] FAIL reset_y: got %0d, required 0", vga_y); end
      checks++;
      if (vga_color !== 3'd0) begin failures++; $display("[TB] FAIL reset_color: got %b, required 000", vga_color); end
      checks++;
      if (plot !== 1'b0) begin failures++; $display("[TB] FAIL reset_plot: got %b, required 0", plot); end
      checks++;
      if (ledr !== 10'd0) begin failures++; $display("[TB] FAIL reset_ledr: got %h, required 000", ledr); end
   endtask

   task automatic test_first_frame();
      bit ab;
      model_reset();
      sb.push_back(model_rec());
      sw = 8'h00;
      @(negedge clk);
      checks++;
      if (plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0) begin
         failures++;
         $display("[TB] FAIL first_pixel_timing: got plot=%b (%0d,%0d), required plot=1 (0,0)", plot, vga_x, vga_y);
      end
      run_frame(4'b0000, -1, ab);
      checks++;
      if (frame_buf[0] !== 3'b111) begin failures++; $display("[TB] FAIL pix_0_0: got %b, required 111", frame_buf[0]); end
      checks++;
      if (frame_buf[90*160] !== 3'b000) begin failures++; $display("[TB] FAIL pix_0_90: got %b, required 000", frame_buf[90*160]); end
      checks++;
      if (frame_buf[89*160+50] !== 3'b000) begin failures++; $display("[TB] FAIL pix_50_89: got %b, required 000", frame_buf[89*160+50]); end
      checks++;
      if (frame_buf[89*160+130] !== 3'b001) begin failures++; $display("[TB] FAIL pix_130_89: got %b, required 001", frame_buf[89*160+130]); end
      check_ledr_after_update("ledr_after_frame0", 10'h000);
   endtask

   // Frame 1 tiles (119,89,59,29): lane0 wraps, lane1 hit, lane3 missed press.
   task automatic test_wrap_hit_miss();
      bit ab;
      run_frame(4'b1010, -1, ab);
      check_ledr_after_update("ledr_wrap_hit_miss", 10'h201);
   endtask

   // Frame 2 tiles (0,0,88,58) paused: lane2 hit, lane0 miss reaches three misses.
   task automatic test_pause_game_over();
      bit ab;
      sw = 8'h02;
      run_frame(4'b0101, -1, ab);
      check_ledr_after_update("ledr_game_over", 10'h302);
   endtask

   task automatic test_abort_mid_frame();
      bit ab;
      run_frame(4'b1111, 60*160 + 80, ab);
      checks++;
      if (frame_buf[0] !== 3'b100) begin failures++; $display("[TB] FAIL game_over_pix: got %b, required 100", frame_buf[0]); end
      sw = 8'h03;
      @(negedge clk);
      checks++;
      if (plot !== 1'b0) begin failures++; $display("[TB] FAIL abort_plot: got %b, required 0", plot); end
      checks++;
      if (ledr !== 10'd0) begin failures++; $display("[TB] FAIL abort_ledr: got %h, required 000", ledr); end
   endtask

   task automatic test_restart();
      bit ab;
      model_reset();
      sb.delete();
      sb.push_back(model_rec());
      @(negedge clk);
      sw = 8'h00;
      @(negedge clk);
      checks++;
      if (plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0) begin
         failures++;
         $display("[TB] FAIL restart_pixel: got plot=%b (%0d,%0d), required plot=1 (0,0)", plot, vga_x, vga_y);
      end
      run_frame(4'b0000, 639, ab);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      sw       = 8'h01;
      key      = 4'hF;
      @(negedge clk);
      test_reset();
      test_first_frame();
      test_wrap_hit_miss();
      test_pause_game_over();
      test_abort_mid_frame();
      test_restart();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
